// File: rtl/fetch_ctrl_if.sv
// Fetch-stage control bundle between the fetch sequencer and the rest of the front end.
//   master : used by fetch_ctrl; samples start, imem_ready, stallD_req, PCSrcM and halt_req,
//            and drives imem_req, stallF, fetch_en, flushD, halted and fault.
//   slave  : used by the surrounding pipeline, with the directions reversed.
// Optional macro FETCH_PERF_EN adds the CNT_W-wide counters perf_fetched, perf_bubbles and
// perf_redirects, driven by the master.
interface fetch_ctrl_if
`ifdef FETCH_PERF_EN
  #(parameter int unsigned CNT_W = 32)
`endif
  ;
  logic start;
  logic imem_ready;
  logic stallD_req;
  logic PCSrcM;
  logic halt_req;
  logic imem_req;
  logic stallF;
  logic fetch_en;
  logic flushD;
  logic halted;
  logic fault;
`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] perf_fetched;
  logic [CNT_W-1:0] perf_bubbles;
  logic [CNT_W-1:0] perf_redirects;
`endif

  modport master (
    input  start, imem_ready, stallD_req, PCSrcM, halt_req,
    output imem_req, stallF, fetch_en, flushD, halted, fault
`ifdef FETCH_PERF_EN
    , output perf_fetched, perf_bubbles, perf_redirects
`endif
  );

  modport slave (
    output start, imem_ready, stallD_req, PCSrcM, halt_req,
    input  imem_req, stallF, fetch_en, flushD, halted, fault
`ifdef FETCH_PERF_EN
    , input perf_fetched, perf_bubbles, perf_redirects
`endif
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the boot/run/halt sequence of the front end and produces the
// PC hold (stallF), fetch/decode register enable (fetch_en) and decode bubble (flushD).
// Instruction-memory waits are bounded by a watchdog that faults after MAX_WAIT consecutive
// not-ready cycles have already been counted.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (returns to IDLE)
//   bus   : fetch_ctrl_if.master (handshake inputs, control outputs)
// Optional macro FETCH_PERF_EN adds saturating performance counters of width CNT_W.
module fetch_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
`ifdef FETCH_PERF_EN
  ,
  parameter int unsigned CNT_W    = 32
`endif
) (
  input logic          clk,
  input logic          reset,
  fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {StIdle, StRun, StWait, StDrain, StHalt, StFault} state_e;

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout;
  logic              imem_req, stallF, fetch_en, flushD, halted, fault;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout = (wait_cnt_q == MaxWait);

  // Next state and wait counter. The counter only increments below MaxWait, so it never wraps.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        if (bus.halt_req) begin
          state_d = StHalt;
        end else if (!bus.PCSrcM && !bus.imem_ready) begin
          state_d    = StWait;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      StWait: begin
        if (bus.halt_req) begin
          state_d = StHalt;
        end else if (bus.PCSrcM) begin
          // An outstanding response belongs to the old PC and must be discarded.
          wait_cnt_d = '0;
          state_d    = bus.imem_ready ? StRun : StDrain;
        end else if (bus.imem_ready) begin
          wait_cnt_d = '0;
          state_d    = StRun;
        end else if (timeout) begin
          state_d = StFault;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      StDrain: begin
        if (bus.halt_req) begin
          state_d = StHalt;
        end else if (bus.PCSrcM) begin
          // Each accepted redirect restarts the wait count.
          wait_cnt_d = '0;
        end else if (bus.imem_ready) begin
          wait_cnt_d = '0;
          state_d    = StRun;
        end else if (timeout) begin
          state_d = StFault;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      StHalt, StFault: begin
        state_d = state_q;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: idle/halt default is hold PC, clock a bubble into decode.
  always_comb begin
    imem_req = 1'b0;
    stallF   = 1'b1;
    fetch_en = 1'b1;
    flushD   = 1'b1;
    halted   = 1'b0;
    fault    = 1'b0;
    unique case (state_q)
      StRun, StWait: begin
        imem_req = 1'b1;
        if (bus.halt_req) begin
          stallF = 1'b1;
        end else if (bus.PCSrcM) begin
          stallF = 1'b0;
        end else if (!bus.imem_ready) begin
          fetch_en = !bus.stallD_req;
        end else if (bus.stallD_req) begin
          fetch_en = 1'b0;
          flushD   = 1'b0;
        end else begin
          stallF = 1'b0;
          flushD = 1'b0;
        end
      end
      StDrain: begin
        if (!bus.halt_req && bus.PCSrcM) stallF = 1'b0;
      end
      StHalt: begin
        halted = 1'b1;
      end
      StFault: begin
        halted = 1'b1;
        fault  = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  assign bus.imem_req = imem_req;
  assign bus.stallF   = stallF;
  assign bus.fetch_en = fetch_en;
  assign bus.flushD   = flushD;
  assign bus.halted   = halted;
  assign bus.fault    = fault;

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] perf_fetched_q, perf_bubbles_q, perf_redirects_q;
  logic             active, redirect;

  assign active   = (state_q == StRun) || (state_q == StWait) || (state_q == StDrain);
  assign redirect = active && !bus.halt_req && bus.PCSrcM;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q   <= '0;
      perf_bubbles_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      if (fetch_en && !flushD && !(&perf_fetched_q)) begin
        perf_fetched_q <= perf_fetched_q + CNT_W'(1);
      end
      if (active && fetch_en && flushD && !(&perf_bubbles_q)) begin
        perf_bubbles_q <= perf_bubbles_q + CNT_W'(1);
      end
      if (redirect && !(&perf_redirects_q)) begin
        perf_redirects_q <= perf_redirects_q + CNT_W'(1);
      end
    end
  end

  assign bus.perf_fetched   = perf_fetched_q;
  assign bus.perf_bubbles   = perf_bubbles_q;
  assign bus.perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios followed by randomized traffic, every cycle
// compared with a behavioural model of the front-end sequencing rules.
module tb_fetch_ctrl;
  localparam int MaxWait = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl #(
    .MAX_WAIT (MaxWait),
    .WAIT_W   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: booted = left idle, stopped = halted or faulted, draining = stale response pending,
  // lows = consecutive not-ready cycles already counted in the current wait.
  bit m_booted = 0, m_stopped = 0, m_faulted = 0, m_draining = 0;
  int m_lows = 0;
  int unsigned m_fetched = 0, m_bubbles = 0, m_redirects = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic expect_out(input logic rdy, sd, pc, hr,
                            output logic req, sf, fe, fl, h, f);
    req = 0; sf = 1; fe = 1; fl = 1; h = 0; f = 0;
    if (m_stopped) begin
      h = 1;
      f = m_faulted;
    end else if (m_booted) begin
      req = !m_draining;
      if (hr) begin
        sf = 1;
      end else if (pc) begin
        sf = 0;
      end else if (m_draining) begin
        sf = 1;
      end else if (!rdy) begin
        fe = !sd;
      end else if (sd) begin
        fe = 0;
        fl = 0;
      end else begin
        sf = 0;
        fl = 0;
      end
    end
  endtask

  task automatic model_update(input logic rs, st, rdy, sd, pc, hr);
    logic req, sf, fe, fl, h, f;
    expect_out(rdy, sd, pc, hr, req, sf, fe, fl, h, f);
    if (rs) begin
      m_booted = 0; m_stopped = 0; m_faulted = 0; m_draining = 0; m_lows = 0;
      m_fetched = 0; m_bubbles = 0; m_redirects = 0;
      return;
    end
    if (fe && !fl) m_fetched++;
    if (m_booted && !m_stopped && fe && fl) m_bubbles++;
    if (m_booted && !m_stopped && !hr && pc) m_redirects++;
    if (!m_booted) begin
      if (st) m_booted = 1;
    end else if (m_stopped) begin
      // absorbing
    end else if (hr) begin
      m_stopped = 1;
    end else if (pc) begin
      if (!m_draining && m_lows > 0) m_draining = !rdy;
      m_lows = 0;
    end else if (rdy) begin
      m_draining = 0;
      m_lows = 0;
    end else if (m_lows == MaxWait) begin
      m_stopped = 1;
      m_faulted = 1;
    end else begin
      m_lows++;
    end
  endtask

  task automatic check_now(input logic rdy, sd, pc, hr);
    logic req, sf, fe, fl, h, f;
    expect_out(rdy, sd, pc, hr, req, sf, fe, fl, h, f);
    chk("imem_req", bus.imem_req, req);
    chk("stallF",   bus.stallF,   sf);
    chk("fetch_en", bus.fetch_en, fe);
    chk("flushD",   bus.flushD,   fl);
    chk("halted",   bus.halted,   h);
    chk("fault",    bus.fault,    f);
`ifdef FETCH_PERF_EN
    chk("perf_fetched",   bus.perf_fetched,   m_fetched);
    chk("perf_bubbles",   bus.perf_bubbles,   m_bubbles);
    chk("perf_redirects", bus.perf_redirects, m_redirects);
`endif
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic rs, st, rdy, sd, pc, hr);
    reset = rs;
    bus.start = st;
    bus.imem_ready = rdy;
    bus.stallD_req = sd;
    bus.PCSrcM = pc;
    bus.halt_req = hr;
    @(negedge clk);
    check_now(rdy, sd, pc, hr);
    @(posedge clk);
    model_update(rs, st, rdy, sd, pc, hr);
    #1;
  endtask

  initial begin
    logic rs, st, rdy, sd, pc, hr;
    bus.start = 0; bus.imem_ready = 0; bus.stallD_req = 0; bus.PCSrcM = 0; bus.halt_req = 0;
    @(posedge clk);
    #1;

    // Reset state and IDLE ignoring everything but start
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    // Boot and steady fetch
    step(0, 1, 0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0, 0);
`ifdef FETCH_PERF_EN
    chk("boot_perf_fetched", bus.perf_fetched, 5);
`endif
    // Decode stall for two cycles, then advance
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    // imem wait of three cycles, then ready
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("wait_no_fault", bus.fault, 0);
    // Redirect on the second WAIT cycle, stale response dropped in DRAIN
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    bus.imem_ready = 1; bus.PCSrcM = 0;
    #1;
    chk("drain_req", bus.imem_req, 0);
    chk("drain_drop_flush", bus.flushD, 1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    // Halt wins over a simultaneous redirect; absorbing afterwards
    step(0, 0, 1, 0, 1, 1);
    chk("halt_next", bus.halted, 1);
    step(0, 1, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);

    // Watchdog: 15 counted lows tolerated, the next low faults
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (MaxWait) step(0, 0, 0, 0, 0, 0);
    chk("fault_not_yet", bus.fault, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("fault_raised", bus.fault, 1);
    step(0, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("fault_cleared", bus.fault, 0);

    // Watchdog also covers DRAIN
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (MaxWait + 1) step(0, 0, 0, 0, 0, 0);
    chk("drain_fault", bus.fault, 1);
    step(1, 0, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs  = m_stopped ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      sd  = ($urandom_range(0, 4) == 0);
      pc  = ($urandom_range(0, 9) == 0);
      hr  = ($urandom_range(0, 99) == 0);
      step(rs, st, rdy, sd, pc, hr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
